// File: rtl/fp_add_pkg.sv
// Shared binary32 constants, special-result encoding and operand unpacking
// for the adder front-end.
package fp_add_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int SIG_W   = 24;
  localparam int ALIGN_W = 27;
  localparam int SHAMT_W = 5;

  localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

  // Encoding of the special-result flag forwarded downstream.
  typedef enum logic [1:0] {
    SPECIAL_NORMAL = 2'b00,
    SPECIAL_NAN    = 2'b01,
    SPECIAL_INF    = 2'b10
  } special_t;

  // Unpacked operand: effective sign, effective exponent (denormal reads
  // as 1), significand with hidden bit, and NaN/inf classification.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] eff_exp;
    logic [SIG_W-1:0] sig;
    logic             is_nan;
    logic             is_inf;
  } fp_unpacked_t;

  // flip inverts the sign, which is how a subtract is folded into b.
  function automatic fp_unpacked_t unpack_fp(input logic [31:0] x, input logic flip);
    fp_unpacked_t u;
    u.sign    = x[31] ^ flip;
    u.eff_exp = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    u.sig     = {x[30:23] != 8'd0, x[22:0]};
    u.is_nan  = (x[30:23] == EXP_SPECIAL) && (x[22:0] != 23'd0);
    u.is_inf  = (x[30:23] == EXP_SPECIAL) && (x[22:0] == 23'd0);
    return u;
  endfunction

endpackage

// File: rtl/fp_add_align_shifter.sv
// Combinational 27-bit right shifter with sticky collection. Amounts above
// 27 are clamped to 27, which shifts every bit out into the sticky bit.
module align_shifter_sticky
  import fp_add_pkg::*;
(
  input  logic [ALIGN_W-1:0] din,
  input  logic [SHAMT_W-1:0] amt,
  output logic [ALIGN_W-1:0] dout
);

  logic [SHAMT_W-1:0] amt_sat;
  logic [ALIGN_W-1:0] shifted;
  logic [ALIGN_W-1:0] lost_mask;
  logic               sticky;

  assign amt_sat = (amt > 5'd27) ? 5'd27 : amt;
  assign shifted = din >> amt_sat;

  // Bit gi of the input is shifted out when it sits below the shift amount.
  for (genvar gi = 0; gi < ALIGN_W; gi++) begin : g_mask
    assign lost_mask[gi] = (5'(gi) < amt_sat);
  end

  assign sticky = |(din & lost_mask);
  assign dout   = {shifted[ALIGN_W-1:1], shifted[0] | sticky};

endmodule

// File: rtl/fp_add_align.sv
// Alignment front-end of the single-precision adder: three-stage pipeline
// (unpack/compare, swap/classify, shift/sticky) with a shared stall.
module fp_add_align
  import fp_add_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  input  logic               op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP_W-1:0]   e_max,
  output logic [SIG_W-1:0]   mant_big,
  output logic [ALIGN_W-1:0] mant_small_al,
  output logic               EOP,
  output logic               sign_r,
  output logic               zero_d,
  output logic [1:0]         special
);

  // All stages advance together whenever the output slot is free or drained.
  logic adv;

  // ---------------- S1: unpack, compare, exponent difference ----------------
  fp_unpacked_t               ua, ub;
  logic [EXP_W+FRAC_W-1:0]    mag_a, mag_b;
  logic                       a_big;
  logic [EXP_W-1:0]           d_next;

  logic                       s1_valid;
  fp_unpacked_t               s1_a, s1_b;
  logic                       s1_a_big;
  logic                       s1_mag_eq;
  logic [EXP_W-1:0]           s1_d;

  assign ua     = unpack_fp(a, 1'b0);
  assign ub     = unpack_fp(b, op);
  assign mag_a  = {ua.eff_exp, ua.sig[FRAC_W-1:0]};
  assign mag_b  = {ub.eff_exp, ub.sig[FRAC_W-1:0]};
  // Ties go to a.
  assign a_big  = (mag_a >= mag_b);
  assign d_next = a_big ? (ua.eff_exp - ub.eff_exp) : (ub.eff_exp - ua.eff_exp);

  // S1 register: unpacked operands plus compare outcome.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_a_big  <= 1'b0;
      s1_mag_eq <= 1'b0;
      s1_d      <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_a      <= ua;
      s1_b      <= ub;
      s1_a_big  <= a_big;
      s1_mag_eq <= (mag_a == mag_b);
      s1_d      <= d_next;
    end
  end

  // ---------------- S2: swap, saturate, effective op, sign, specials --------
  fp_unpacked_t               big_op, small_op;
  logic                       eop_next;
  logic                       sign_next;
  special_t                   special_next;
  logic [SHAMT_W-1:0]         amt_next;

  logic                       s2_valid;
  logic [EXP_W-1:0]           s2_e_max;
  logic [SIG_W-1:0]           s2_mant_big;
  logic [SIG_W-1:0]           s2_sig_small;
  logic [SHAMT_W-1:0]         s2_amt;
  logic                       s2_eop;
  logic                       s2_sign_r;
  logic                       s2_zero_d;
  special_t                   s2_special;

  // Swap operands, clamp shift, and classify NaN/inf before any arithmetic.
  always_comb begin
    big_op       = s1_a_big ? s1_a : s1_b;
    small_op     = s1_a_big ? s1_b : s1_a;
    eop_next     = s1_a.sign ^ s1_b.sign;
    amt_next     = (s1_d >= 8'd27) ? 5'd27 : s1_d[SHAMT_W-1:0];
    sign_next    = big_op.sign;
    special_next = SPECIAL_NORMAL;
    // Exact cancellation yields +0 under round-to-nearest.
    if (eop_next && s1_mag_eq) begin
      sign_next = 1'b0;
    end
    if (s1_a.is_nan || s1_b.is_nan) begin
      special_next = SPECIAL_NAN;
    end else if (s1_a.is_inf && s1_b.is_inf && eop_next) begin
      special_next = SPECIAL_NAN;
    end else if (s1_a.is_inf) begin
      special_next = SPECIAL_INF;
      sign_next    = s1_a.sign;
    end else if (s1_b.is_inf) begin
      special_next = SPECIAL_INF;
      sign_next    = s1_b.sign;
    end
  end

  // S2 register: selected operands and control flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid     <= 1'b0;
      s2_e_max     <= '0;
      s2_mant_big  <= '0;
      s2_sig_small <= '0;
      s2_amt       <= '0;
      s2_eop       <= 1'b0;
      s2_sign_r    <= 1'b0;
      s2_zero_d    <= 1'b0;
      s2_special   <= SPECIAL_NORMAL;
    end else if (adv) begin
      s2_valid     <= s1_valid;
      s2_e_max     <= big_op.eff_exp;
      s2_mant_big  <= big_op.sig;
      s2_sig_small <= small_op.sig;
      s2_amt       <= amt_next;
      s2_eop       <= eop_next;
      s2_sign_r    <= sign_next;
      s2_zero_d    <= (s1_d == 8'd0);
      s2_special   <= special_next;
    end
  end

  // ---------------- S3: barrel shift with sticky, output registers ----------
  logic [ALIGN_W-1:0] shifted_small;

  align_shifter_sticky u_shift (
    .din  ({s2_sig_small, 3'b000}),
    .amt  (s2_amt),
    .dout (shifted_small)
  );

  logic               out_valid_reg;
  logic [EXP_W-1:0]   e_max_reg;
  logic [SIG_W-1:0]   mant_big_reg;
  logic [ALIGN_W-1:0] mant_small_al_reg;
  logic               eop_reg;
  logic               sign_r_reg;
  logic               zero_d_reg;
  special_t           special_reg;

  // Output register; holds while a valid result waits for out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg     <= 1'b0;
      e_max_reg         <= '0;
      mant_big_reg      <= '0;
      mant_small_al_reg <= '0;
      eop_reg           <= 1'b0;
      sign_r_reg        <= 1'b0;
      zero_d_reg        <= 1'b0;
      special_reg       <= SPECIAL_NORMAL;
    end else if (adv) begin
      out_valid_reg     <= s2_valid;
      e_max_reg         <= s2_e_max;
      mant_big_reg      <= s2_mant_big;
      mant_small_al_reg <= shifted_small;
      eop_reg           <= s2_eop;
      sign_r_reg        <= s2_sign_r;
      zero_d_reg        <= s2_zero_d;
      special_reg       <= s2_special;
    end
  end

  assign adv           = !out_valid_reg || out_ready;
  assign in_ready      = adv;
  assign out_valid     = out_valid_reg;
  assign e_max         = e_max_reg;
  assign mant_big      = mant_big_reg;
  assign mant_small_al = mant_small_al_reg;
  assign EOP           = eop_reg;
  assign sign_r        = sign_r_reg;
  assign zero_d        = zero_d_reg;
  assign special       = special_reg;

endmodule

// File: tb/tb_fp_add_align.sv
// Self-checking bench for fp_add_align: directed vectors, a stalled stream,
// randomized traffic and a mid-stream reset, checked against an
// arithmetic reference model and an abstract 3-slot lockstep pipeline.
module tb_fp_add_align;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  e_max;
  logic [23:0] mant_big;
  logic [26:0] mant_small_al;
  logic        EOP;
  logic        sign_r;
  logic        zero_d;
  logic [1:0]  special;

  int checks = 0;
  int passed = 0;

  // Abstract pipeline: three slots shifting together, slot 2 is the output.
  logic        m_v [3];
  logic [63:0] m_d [3];
  logic        prev_rst = 1'b0;

  fp_add_align dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .a             (a),
    .b             (b),
    .op            (op),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .e_max         (e_max),
    .mant_big      (mant_big),
    .mant_small_al (mant_small_al),
    .EOP           (EOP),
    .sign_r        (sign_r),
    .zero_d        (zero_d),
    .special       (special)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {e_max, mant_big, mant_small_al, EOP, sign_r, zero_d, special}.
  function automatic logic [63:0] ref_model(input logic [31:0] xa, input logic [31:0] xb,
                                            input logic xop);
    int     ea, eb, effa, effb, d, ebig;
    longint fa, fb, maga, magb, siga, sigb, sig_big, sig_sml, x, res, rem;
    bit     sa, sb, a_big, eop, sr, nan_a, nan_b, inf_a, inf_b;
    logic [1:0] sp;
    ea   = int'(xa[30:23]);
    eb   = int'(xb[30:23]);
    fa   = longint'(xa[22:0]);
    fb   = longint'(xb[22:0]);
    sa   = xa[31];
    sb   = xb[31] ^ xop;
    effa = (ea == 0) ? 1 : ea;
    effb = (eb == 0) ? 1 : eb;
    siga = ((ea != 0) ? 64'd8388608 : 64'd0) + fa;
    sigb = ((eb != 0) ? 64'd8388608 : 64'd0) + fb;
    maga = longint'(effa) * 8388608 + fa;
    magb = longint'(effb) * 8388608 + fb;
    a_big   = (maga >= magb);
    ebig    = a_big ? effa : effb;
    d       = a_big ? effa - effb : effb - effa;
    sig_big = a_big ? siga : sigb;
    sig_sml = a_big ? sigb : siga;
    if (d >= 27) begin
      res = (sig_sml != 0) ? 1 : 0;
    end else begin
      x   = sig_sml * 8;
      res = x >> d;
      rem = x % (longint'(1) << d);
      if (rem != 0) res = res | 1;
    end
    eop = sa ^ sb;
    sr  = a_big ? sa : sb;
    if (eop && maga == magb) sr = 1'b0;
    nan_a = (ea == 255) && (fa != 0);
    nan_b = (eb == 255) && (fb != 0);
    inf_a = (ea == 255) && (fa == 0);
    inf_b = (eb == 255) && (fb == 0);
    sp = 2'b00;
    if (nan_a || nan_b) sp = 2'b01;
    else if (inf_a && inf_b && eop) sp = 2'b01;
    else if (inf_a) begin sp = 2'b10; sr = sa; end
    else if (inf_b) begin sp = 2'b10; sr = sb; end
    return {8'(ebig), 24'(sig_big), 27'(res), eop, sr, (d == 0), sp};
  endfunction

  function automatic logic [31:0] rand_fp(input int base);
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 15);
    if (k == 0) begin
      r[30:23] = 8'hFF;
      if ($urandom_range(0, 1) == 0) r[22:0] = '0;
    end else if (k == 1) begin
      r[30:23] = 8'h00;
    end else if (k >= 4) begin
      r[30:23] = 8'(base + $urandom_range(0, 34) - 17);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance model.
  task automatic step(input logic v, input logic [31:0] ia, input logic [31:0] ib,
                      input logic iop, input logic ordy, input logic irst, output logic acc);
    logic        adv_m;
    logic [63:0] outs;
    in_valid  = v;
    a         = ia;
    b         = ib;
    op        = iop;
    out_ready = ordy;
    rst       = irst;
    @(negedge clk);
    outs  = {e_max, mant_big, mant_small_al, EOP, sign_r, zero_d, special};
    adv_m = !m_v[2] || ordy;
    if (prev_rst) check("reset_outputs", {63'd0, out_valid} | outs, 64'd0);
    check("in_ready", 64'(in_ready), 64'(adv_m));
    check("out_valid", 64'(out_valid), 64'(m_v[2]));
    if (m_v[2]) check("result", outs, m_d[2]);
    acc = 1'b0;
    if (irst) begin
      for (int i = 0; i < 3; i++) m_v[i] = 1'b0;
    end else if (adv_m) begin
      m_v[2] = m_v[1]; m_d[2] = m_d[1];
      m_v[1] = m_v[0]; m_d[1] = m_d[0];
      m_v[0] = v;      m_d[0] = ref_model(ia, ib, iop);
      acc    = v;
    end
    if (m_v[2] && ordy && !irst && !prev_rst)
      $display("emit e_max=%h mant_big=%h small=%h eop=%b sign=%b zd=%b sp=%b",
               e_max, mant_big, mant_small_al, EOP, sign_r, zero_d, special);
    prev_rst = irst;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] dir_a  [6] = '{32'h3F800000, 32'h3F800000, 32'h3FC00000,
                              32'h40000000, 32'h7F800000, 32'hFF800000};
  logic [31:0] dir_b  [6] = '{32'h3F800000, 32'h30800000, 32'h40400000,
                              32'h40000000, 32'h7F800000, 32'h3F800000};
  logic        dir_op [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic        stall_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    logic        acc;
    logic [31:0] sa [8];
    logic [31:0] sb [8];
    logic        sop [8];
    int          idx, cyc, base;

    for (int i = 0; i < 3; i++) begin m_v[i] = 1'b0; m_d[i] = '0; end
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset, then check the idle state.
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, acc);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, acc);

    // Directed vectors including exact cancellation and specials.
    for (int i = 0; i < 6; i++) step(1'b1, dir_a[i], dir_b[i], dir_op[i], 1'b1, 1'b0, acc);
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, acc);

    // Back-to-back stream of 8 with out_ready pattern 1,0,0,1.
    for (int i = 0; i < 8; i++) begin
      sa[i] = rand_fp(127); sb[i] = rand_fp(127); sop[i] = 1'($urandom_range(0, 1));
    end
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 200) begin
      step(1'b1, sa[idx], sb[idx], sop[idx], stall_pat[cyc % 4], 1'b0, acc);
      if (acc) idx++;
      cyc++;
    end
    check("stream_accepted", 64'(idx), 64'd8);
    for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, acc);

    // Randomized traffic with random bubbles and back-pressure.
    for (int i = 0; i < 400; i++) begin
      base = $urandom_range(20, 230);
      step(1'($urandom_range(0, 3) != 0), rand_fp(base), rand_fp(base),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'b0, acc);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, acc);

    // Mid-stream reset flushes three in-flight operands.
    for (int i = 0; i < 3; i++) step(1'b1, rand_fp(100), rand_fp(100), 1'b0, 1'b1, 1'b0, acc);
    step(1'b1, rand_fp(100), rand_fp(100), 1'b0, 1'b1, 1'b1, acc);
    step(1'b1, 32'h3F800000, 32'h3F000000, 1'b1, 1'b1, 1'b0, acc);
    for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, acc);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
